// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS32 MEM stage and a word-wide data memory.
// Handles byte/halfword/word loads with extension, sub-word stores via
// read-modify-write, and flags misaligned or illegal requests.
module load_store_unit #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              addr_error,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    ERR
  } state_t;

  state_t            r_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_write;
  logic              r_mem_read;

  logic              w_misaligned;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_merged;

  // Strobes are forced low while reset is high so an in-flight write is aborted.
  assign mem_write = r_mem_write & ~reset;
  assign mem_read  = r_mem_read  & ~reset;

  // Classify the incoming request as misaligned or illegal.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  // Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte = '0;
    case (r_off)
      2'd0:    w_byte = mem_read_data[31:24];
      2'd1:    w_byte = mem_read_data[23:16];
      2'd2:    w_byte = mem_read_data[15:8];
      default: w_byte = mem_read_data[7:0];
    endcase
    w_half = r_off[1] ? mem_read_data[15:0] : mem_read_data[31:16];

    w_load_ext = mem_read_data;
    if (r_size == 2'b00) begin
      w_load_ext = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (r_size == 2'b01) begin
      w_load_ext = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
    end

    w_merged = mem_read_data;
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0:    w_merged[31:24] = r_wdata[7:0];
        2'd1:    w_merged[23:16] = r_wdata[7:0];
        2'd2:    w_merged[15:8]  = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_off[1]) begin
      w_merged[15:0] = r_wdata[15:0];
    end else begin
      w_merged[31:16] = r_wdata[15:0];
    end
  end

  // Access sequencer with registered handshake and memory outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_write        <= 1'b0;
      r_size         <= '0;
      r_unsigned     <= 1'b0;
      r_off          <= '0;
      r_wdata        <= '0;
      r_mem_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      addr_error     <= 1'b0;
      load_data      <= '0;
      mem_adress     <= '0;
      mem_write_data <= '0;
    end else begin
      done       <= 1'b0;
      addr_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            busy       <= 1'b1;
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            if (w_misaligned) begin
              r_state    <= ERR;
              done       <= 1'b1;
              addr_error <= 1'b1;
            end else begin
              mem_adress <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_write && req_size == 2'b10) begin
                r_state        <= WR;
                r_mem_write    <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                r_state    <= RD1;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        RD1: r_state <= RD2;
        RD2: begin
          r_mem_read <= 1'b0;
          if (r_write) begin
            r_state        <= WR;
            r_mem_write    <= 1'b1;
            mem_write_data <= w_merged;
          end else begin
            r_state   <= IDLE;
            load_data <= w_load_ext;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        WR: begin
          r_state     <= IDLE;
          r_mem_write <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        ERR: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
